// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive-side byte buffer between uart_rx and its consumer. The byte-ready
//   level from uart_rx (clk_speed domain) is synchronised into clk. Each rising
//   edge captures one byte into a first-word-fall-through FIFO. When a byte
//   arrives with the queue full and no pop in the same cycle, the byte is
//   dropped and a sticky overflow flag is raised.
//
// Ports
//   clk_i       system clock
//   rst_i       asynchronous, active-high reset
//   rx_data_i   byte from uart_rx, stable while rx_ready_i is high
//   rx_ready_i  byte-ready level, asynchronous to clk_i
//   rd_en_i     pop request, honoured only while rd_valid_o is high
//   rd_data_o   head-of-queue byte, 0 when empty
//   rd_valid_o  queue non-empty
//   count_o     bytes stored, 0..DEPTH
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
//   overflow_o  sticky: a byte was dropped because the queue was full
//   ovf_clr_i   synchronous clear of overflow_o (a drop in the same cycle wins)

module uart_rx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_ready_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              overflow_o,
    input  logic              ovf_clr_i
);

    localparam logic [ADDR_W:0]   CountOne  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CountFull = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser and edge detector
    // ------------------------------------------------------------------
    // The chain resets to all ones so that a ready level already high when
    // reset is released looks like "no edge" and produces no push.
    logic s1_q, s2_q, s3_q;
    logic push_req;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= rx_ready_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s1 is the metastability stage; the edge is taken between s2 and s3.
    assign push_req = s2_q & ~s3_q;

    // ------------------------------------------------------------------
    // FIFO control state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q,  count_d;
    logic              full_q,   full_d;
    logic              empty_q,  empty_d;
    logic              overflow_q, overflow_d;

    logic pop;
    logic push;
    logic drop;

    // A pop frees a slot in the same cycle, so a full queue still accepts a
    // byte when the consumer pops alongside it.
    assign pop  = rd_en_i & ~empty_q;
    assign push = push_req & (~full_q | pop);
    assign drop = push_req & full_q & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase

        // Set has priority over clear so a drop is never lost.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end

        full_d  = (count_d == CountFull);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Contents are deliberately not reset; they are only visible through
    // rd_data_o, which is forced to zero while the queue is empty.
    logic [DATA_W-1:0] mem_q [DEPTH];

    // rx_data_i is sampled directly: upstream holds it stable well beyond
    // the synchroniser latency, so it is settled by the push cycle.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rx_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        rd_data_o = '0;
        if (!empty_q) begin
            rd_data_o = mem_q[rd_ptr_q];
        end
    end

    assign rd_valid_o = ~empty_q;
    assign count_o    = count_q;
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = overflow_q;

endmodule
